// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-back controller with post-reset clear and round-robin arbitration
//
// Purpose:
//   After reset, clears every register of the file by writing zero to
//   addresses 0..NUM_REGS-1, one per cycle. Then it shares the single write
//   port between two write-back requesters, ALU (port 0) and load unit
//   (port 1), using round-robin arbitration with a valid/ready handshake.
//   The write is registered, so rf_rw/rf_rd/rf_din appear one cycle after
//   the accept edge. Writes to register 0 are accepted but not strobed.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req0_valid/rd/data    ALU write request          req0_ready  accept
//   req1_valid/rd/data    load-unit write request    req1_ready  accept
//   rf_enable             register file enable (1 every cycle after reset)
//   rf_rw                 register file write strobe
//   rf_rd, rf_din         register file write address / data
//   init_busy             high while the clear sequence runs
//   last_grant            port granted most recently

module rf_wb_arbiter #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_rd,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_rd,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_enable,
   output logic              rf_rw,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_din,
   output logic              init_busy,
   output logic              last_grant
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // One extra counter bit so the terminal count NUM_REGS is representable;
   // the cycle spent at that count is the idle cycle before RUN.
   localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                en_q, en_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                lg_q, lg_d;
   logic                ready0, ready1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         rd_q    <= '0;
         din_q   <= '0;
         lg_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         rd_q    <= rd_d;
         din_q   <= din_d;
         lg_q    <= lg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = 1'b1;
      rw_d    = 1'b0;
      rd_d    = rd_q;
      din_d   = din_q;
      lg_d    = lg_q;
      ready0  = 1'b0;
      ready1  = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            if (cnt_q != CLR_END) begin
               rw_d  = 1'b1;
               rd_d  = cnt_q[ADDR_W-1:0];
               din_d = '0;
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // On a tie the port that did not win last time gets the grant.
            ready0 = req0_valid && (!req1_valid || lg_q);
            ready1 = req1_valid && (!req0_valid || !lg_q);

            if (ready0) begin
               lg_d  = 1'b0;
               rd_d  = req0_rd;
               din_d = req0_data;
               rw_d  = (req0_rd != '0);
            end else if (ready1) begin
               lg_d  = 1'b1;
               rd_d  = req1_rd;
               din_d = req1_data;
               rw_d  = (req1_rd != '0);
            end
         end

         default: state_d = ST_CLEAR;
      endcase
   end

   assign req0_ready = ready0 && !reset;
   assign req1_ready = ready1 && !reset;
   assign rf_enable  = en_q;
   assign rf_rw      = rw_q;
   assign rf_rd      = rd_q;
   assign rf_din     = din_q;
   assign init_busy  = (state_q == ST_CLEAR);
   assign last_grant = lg_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter

module tb_rf_wb_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk;
   logic              reset;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_rd, req1_rd;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              req0_ready, req1_ready;
   logic              rf_enable, rf_rw;
   logic [ADDR_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_din;
   logic              init_busy, last_grant;

   int n_checks = 0;
   int n_fail   = 0;
   int writes_seen = 0;

   logic [ADDR_W+DATA_W-1:0] sb[$];

   rf_wb_arbiter #(.NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_rd    (req0_rd),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rd    (req1_rd),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rf_enable  (rf_enable),
      .rf_rw      (rf_rw),
      .rf_rd      (rf_rd),
      .rf_din     (rf_din),
      .init_busy  (init_busy),
      .last_grant (last_grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
      sb.push_back({rd, d});
   endtask

   task automatic push_clear(input int n);
      for (int i = 0; i < n; i++) push(ADDR_W'(i), '0);
   endtask

   // Every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rf_rw === 1'b1) begin
         logic [ADDR_W+DATA_W-1:0] e;
         writes_seen++;
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_rd", 64'(rf_rd), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("wr_din", 64'(rf_din), 64'(e[DATA_W-1:0]));
         end
      end
   end

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_enable"}, 64'(rf_enable), 64'd0);
      chk({pfx, "_rw"}, 64'(rf_rw), 64'd0);
      chk({pfx, "_rd"}, 64'(rf_rd), 64'd0);
      chk({pfx, "_din"}, 64'(rf_din), 64'd0);
      chk({pfx, "_busy"}, 64'(init_busy), 64'd1);
      chk({pfx, "_lg"}, 64'(last_grant), 64'd1);
      chk({pfx, "_rdy0"}, 64'(req0_ready), 64'd0);
   endtask

   initial begin
      logic lg;
      logic g;

      reset      = 1'b1;
      req0_valid = 1'b1;
      req0_rd    = 5'd7;
      req0_data  = 32'hA5A5_A5A5;
      req1_valid = 1'b0;
      req1_rd    = '0;
      req1_data  = '0;

      // Reset state, with a request already pending that must wait.
      repeat (3) step();
      chk_reset_vals("rst");

      // Clear sequence: E1..E32 write 0..31, E33 enters RUN.
      push_clear(32);
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         step();
         chk("clr_busy", 64'(init_busy), 64'd1);
         chk("clr_rdy0", 64'(req0_ready), 64'd0);
         chk("clr_en", 64'(rf_enable), 64'd1);
      end
      step();
      chk("e33_busy", 64'(init_busy), 64'd0);
      chk("e33_rw", 64'(rf_rw), 64'd0);
      chk("clr_writes", 64'(writes_seen), 64'd32);
      chk("run_rdy0", 64'(req0_ready), 64'd1);
      push(5'd7, 32'hA5A5_A5A5);
      step();
      req0_valid = 1'b0;
      chk("held_rw", 64'(rf_rw), 64'd1);
      chk("held_lg", 64'(last_grant), 64'd0);

      // Single ALU write, back-to-back with the held request.
      req0_valid = 1'b1;
      req0_rd    = 5'd5;
      req0_data  = 32'hDEAD_BEEF;
      #1;
      chk("one_rdy0", 64'(req0_ready), 64'd1);
      chk("one_rdy1", 64'(req1_ready), 64'd0);
      push(5'd5, 32'hDEAD_BEEF);
      step();
      req0_valid = 1'b0;
      chk("one_rw", 64'(rf_rw), 64'd1);
      step();
      chk("one_rw_drop", 64'(rf_rw), 64'd0);

      // Load-unit write to register 0: accepted, never strobed.
      req1_valid = 1'b1;
      req1_rd    = 5'd0;
      req1_data  = 32'hFFFF_FFFF;
      #1;
      chk("r0_rdy1", 64'(req1_ready), 64'd1);
      chk("r0_rdy0", 64'(req0_ready), 64'd0);
      step();
      req1_valid = 1'b0;
      chk("r0_lg", 64'(last_grant), 64'd1);
      chk("r0_rw", 64'(rf_rw), 64'd0);

      // Both ports continuously valid: grants alternate starting with port 0.
      lg = 1'b1;
      req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
      req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
      for (int c = 0; c < 4; c++) begin
         #1;
         g = ~lg;
         chk("rr_rdy0", 64'(req0_ready), 64'(g == 1'b0));
         chk("rr_rdy1", 64'(req1_ready), 64'(g == 1'b1));
         if (g) push(5'd2, 32'h22);
         else   push(5'd1, 32'h11);
         lg = g;
         step();
         chk("rr_rw", 64'(rf_rw), 64'd1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      step();
      chk("rr_drain", 64'(sb.size()), 64'd0);
      chk("rr_lg", 64'(last_grant), 64'(lg));

      // Reset in the middle of the clear, then a full restart.
      reset = 1'b1;
      step();
      reset = 1'b0;
      push_clear(10);
      repeat (10) step();
      reset = 1'b1;
      step();
      chk_reset_vals("mid");
      chk("mid_sb", 64'(sb.size()), 64'd0);
      reset = 1'b0;
      push_clear(32);
      repeat (33) step();
      chk("re_busy", 64'(init_busy), 64'd0);
      chk("re_sb", 64'(sb.size()), 64'd0);
      chk("total_writes", 64'(writes_seen), 64'd80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back controller for the 32x32 register file. It sequences a zero-fill of every register after reset. It then shares the file's single write port between two write-back requesters, the ALU (port 0) and the load unit (port 1), using round-robin arbitration with a valid/ready handshake. It sits between the execute/memory stages and the register file's `enable`/`rw`/`rd`/`din` inputs, and keeps `enable` asserted so read ports stay live.

## Interface

Parameters:

- `NUM_REGS`, 32: registers to clear; must equal 2^`ADDR_W`.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: data width.

Ports:

- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `req0_valid`, in, 1: ALU write request.
- `req0_rd`, in, `ADDR_W`: ALU destination register.
- `req0_data`, in, `DATA_W`: ALU result.
- `req0_ready`, out, 1: ALU request accepted this cycle.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready`: same as port 0, for the load unit.
- `rf_enable`, out, 1: register file enable.
- `rf_rw`, out, 1: register file write strobe.
- `rf_rd`, out, `ADDR_W`: register file write address.
- `rf_din`, out, `DATA_W`: register file write data.
- `init_busy`, out, 1: high while the clear sequence runs.
- `last_grant`, out, 1: port granted most recently (0 or 1).

## Operation

- States: CLEAR and RUN. Reset forces CLEAR, clear counter = 0, `last_grant` = 1 (so port 0 wins the first tie).
- CLEAR:
  - Each cycle: registered `rf_enable`=1, `rf_rw`=1, `rf_rd`=counter, `rf_din`=0; counter increments.
  - After the write to `NUM_REGS`-1, go to RUN.
  - `req0_ready` and `req1_ready` are held 0 throughout.
- RUN arbitration (combinational):
  - Only one valid: that port gets ready=1.
  - Both valid: the port other than `last_grant` gets ready=1, the loser gets 0.
  - At most one ready is ever high.
- RUN accept:
  - Accept = valid && ready.
  - On accept, `last_grant` updates to the accepted port.
  - Next cycle: `rf_rw`=1, `rf_rd`/`rf_din` = accepted rd/data.
  - With no accept, `rf_rw`=0 and `rf_rd`/`rf_din` hold their previous values.
- Writes to register 0: the request is accepted (ready=1, `last_grant` updates), but `rf_rw` stays 0. Register 0 is never written after the clear.
- `rf_enable` is 1 in every cycle after reset deasserts, in both states.
- Requesters must hold `valid`/`rd`/`data` stable until accepted. The block does not buffer requests.

## Timing

- Reset values of all registered outputs: `rf_enable`=0, `rf_rw`=0, `rf_rd`=0, `rf_din`=0, `init_busy`=1, `last_grant`=1. Ready outputs are 0 during reset.
- Clear sequence, with the last reset-high edge as E0:
  - Edges E1..E32: `rf_rw`=1, `rf_rd`=0..31.
  - Edge E33: `rf_rw`=0, `init_busy`=0, state=RUN.
  - The first ready can be high in the cycle following E33.
- Write latency: exactly 1 cycle from the accept edge to `rf_rw`/`rf_rd`/`rf_din` valid. The strobe lasts 1 cycle.
- Throughput: one write per cycle. Back-to-back accepts give a continuous `rf_rw`.
- Reset asserted mid-clear or mid-RUN:
  - Next edge restores all reset values.
  - Any pending write is dropped.
  - The clear restarts from register 0.
- The counter uses `ADDR_W`+1 bits so the terminal count does not wrap.

## Test plan

- Reset, then idle 40 cycles -> `rf_rw`=1 for exactly 32 cycles with `rf_rd`=0,1,…,31 and `rf_din`=0; `init_busy` falls at E33; readies stay 0 until then.
- After init, `req0` only, rd=5, data=0xDEADBEEF -> `req0_ready`=1 the same cycle; next cycle `rf_rw`=1, `rf_rd`=5, `rf_din`=0xDEADBEEF; then `rf_rw`=0.
- Both ports valid continuously for 4 cycles (rd=1/data=0x11, rd=2/data=0x22) -> grants 0,1,0,1; `rf_rd` sequence 1,2,1,2, one cycle behind the grants.
- `req1` with rd=0, data=0xFFFFFFFF -> `req1_ready`=1 and `last_grant`=1, but `rf_rw` stays 0.
- Assert reset at the 10th clear cycle -> next edge gives reset values; the clear restarts at `rf_rd`=0 and runs all 32 writes.
- Request held during CLEAR -> ready stays 0; the request is accepted in the first RUN cycle and written one cycle later.
